csh_fill_seq: RTL and testbench
===============================

# csh_fill_seq

Cache line-fill write sequencer. Accepts a fill request for one cache way, takes four 36-bit memory words over a ready/valid handshake, and drives the cache data RAM slices with per-word write strobes, way selects, word address and a generated parity bit. It sits directly upstream of the cache data slices: the memory-to-cache data bus, per-way select/write lines and the parity-in bit all originate here.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256, cycles allowed in WAIT_DATA before abort (used only with CSH_FILL_TIMEOUT_EN).

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset_l  in  1  asynchronous, active-low reset.
- fill_req_h  in  1  start a line fill (sampled in IDLE only).
- fill_way_h  in  2  target way 0-3, captured with fill_req_h.
- fill_wd_h  in  2  first word of line (cache_adr 34-35), captured with fill_req_h.
- fill_abort_h  in  1  cancel fill in progress.
- mem_data_h  in  36  memory word, bit 0 = MSB (PDP-10 numbering).
- mem_valid_h  in  1  mem_data_h valid.
- mem_rdy_h  out  1  sequencer can accept a word.
- mem_to_cache_h  out  36  registered write data to data slices.
- csh_par_bit_in_h  out  1  odd parity bit for mem_to_cache_h.
- cache_wd_adr_h  out  2  word address (cache_adr 34-35) for current write.
- csh_sel_l  out  4  per-way select, active low, one-hot-low.
- cache_wr_l  out  4  per-way write strobe, active low.
- fill_busy_h  out  1  high in any state but IDLE.
- fill_done_h  out  1  one-cycle pulse after fourth write.
- fill_err_h  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, WAIT_DATA, WRITE, DONE.
- IDLE: fill_req_h=1 captures way and first word into way_r/wd_r, word count cnt=0, -> WAIT_DATA.
- WAIT_DATA: mem_rdy_h=1. Transfer when mem_valid_h & mem_rdy_h: data latched into mem_to_cache_h, parity computed, -> WRITE. mem_valid_h outside WAIT_DATA is ignored (no transfer).
- WRITE: csh_sel_l[way_r]=0, cache_wr_l[way_r]=0, cache_wd_adr_h=wd_r for exactly one cycle. On exit wd_r increments mod 4 (3 wraps to 0), cnt increments; cnt==3 on exit -> DONE, else -> WAIT_DATA.
- DONE: fill_done_h=1 for one cycle, -> IDLE.
- Parity: csh_par_bit_in_h = XNOR reduction of mem_to_cache_h (37-bit total has odd ones count); all-zero word gives 1.
- fill_req_h while busy: ignored, not queued.
- fill_abort_h: any state -> IDLE at next edge; write strobe already asserted in the current WRITE cycle completes; no further writes, no done pulse. Abort has priority over transfer, timeout and state advance in the same cycle.
- Non-selected ways: csh_sel_l and cache_wr_l bits stay 1 at all times.

## Timing
- Reset values: state IDLE, mem_to_cache_h=0, csh_par_bit_in_h=1, cache_wd_adr_h=0, csh_sel_l=4'b1111, cache_wr_l=4'b1111, mem_rdy_h=0, fill_busy_h=0, fill_done_h=0, fill_err_h=0, cnt=0.
- All outputs registered (state-decoded from registers); no combinational input-to-output path.
- fill_req_h at edge N -> mem_rdy_h=1 from cycle after N.
- Transfer at edge M -> write strobe low in cycle M+1; data, parity, select and word address stable the full strobe cycle.
- Maximum rate: one word per two cycles; minimum fill with back-to-back valid = 1+4x2+1 = 10 cycles req-to-idle.
- Reset asserted mid-fill: outputs return to reset values asynchronously; strobe deasserts immediately.

## Configuration
- CSH_FILL_TIMEOUT_EN defined: 9-bit counter clears on entry to WAIT_DATA, counts each WAIT_DATA cycle; reaching TIMEOUT_CYCLES with no transfer -> fill_err_h one-cycle pulse, -> IDLE, no done pulse.
- Undefined: no counter; WAIT_DATA waits indefinitely; fill_err_h tied 0.

## Test plan
- Reset: reset_l=0 mid-WRITE -> cache_wr_l=4'b1111, csh_sel_l=4'b1111, state IDLE immediately; all outputs at reset values.
- Basic fill: way=2, first word=1, four words 0o1,0o2,0o3,0o4 valid back-to-back -> cache_wr_l=4'b1011 four single cycles at word addresses 1,2,3,0, fill_done_h pulse 10 cycles after req.
- Parity: words 36'o0, 36'o1, 36'o777777777777, 36'o400000000001 -> csh_par_bit_in_h 1,0,1,1.
- Stall/ignore: mem_valid_h held 1 during WRITE and DONE, second fill_req_h while busy -> no extra writes, no second fill, exactly four strobes.
- Abort: fill_abort_h after second write -> IDLE next edge, only two strobes, no fill_done_h, mem_rdy_h=0.
- Timeout (CSH_FILL_TIMEOUT_EN, TIMEOUT_CYCLES=256): no valid after req -> fill_err_h pulse after 256 WAIT_DATA cycles, fill_busy_h falls; without macro -> busy stays high.

Source files
------------

// File: rtl/csh_fill_seq.sv
// csh_fill_seq: cache line-fill write sequencer.
// Takes one fill request (way + first word), accepts four 36-bit memory words
// over a ready/valid handshake, and writes each word into the selected cache
// way with its own active-low select/write strobe, word address and odd parity.
// Optional feature macro: CSH_FILL_TIMEOUT_EN. When it is defined, a fill that
// waits TIMEOUT_CYCLES cycles for a word is abandoned with an error pulse.
// Every output comes straight from a flop.

module csh_fill_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        fill_req_h,
  input  logic [1:0]  fill_way_h,
  input  logic [1:0]  fill_wd_h,
  input  logic        fill_abort_h,
  input  logic [0:35] mem_data_h,
  input  logic        mem_valid_h,
  output logic        mem_rdy_h,
  output logic [0:35] mem_to_cache_h,
  output logic        csh_par_bit_in_h,
  output logic [1:0]  cache_wd_adr_h,
  output logic [3:0]  csh_sel_l,
  output logic [3:0]  cache_wr_l,
  output logic        fill_busy_h,
  output logic        fill_done_h,
  output logic        fill_err_h
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_WRITE     = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  state_e     r_state;
  state_e     w_next;
  logic [1:0] r_way;
  logic [1:0] r_wd;
  logic [1:0] r_cnt;
  logic       w_xfer;
  logic       w_tmo;
  logic       w_tmo_exit;

  // mem_rdy_h is high exactly in WAIT_DATA, so this is the handshake itself.
  assign w_xfer     = mem_rdy_h & mem_valid_h;
  // Timeout only wins when no word arrives and no abort is pending.
  assign w_tmo_exit = (r_state == S_WAIT_DATA) & w_tmo & ~mem_valid_h & ~fill_abort_h;

  // The word address register drives the data slices directly.
  assign cache_wd_adr_h = r_wd;

`ifdef CSH_FILL_TIMEOUT_EN
  localparam logic [8:0] TMO_LAST = 9'(TIMEOUT_CYCLES - 1);

  logic [8:0] r_tmo_cnt;

  assign w_tmo = (r_tmo_cnt == TMO_LAST);

  // Wait-cycle counter: held at zero outside WAIT_DATA, so it is clear on entry.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_tmo_cnt <= '0;
    end else if (r_state != S_WAIT_DATA) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 9'd1;
    end
  end
`else
  // Timeout disabled: the parameter has no effect in this build.
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign w_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others, independent of block order.
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    // NOTE: default first, so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    if (fill_abort_h) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (fill_req_h) w_next = S_WAIT_DATA;
        S_WAIT_DATA: begin
          if (w_xfer)          w_next = S_WRITE;
          else if (w_tmo_exit) w_next = S_IDLE;
        end
        S_WRITE:     w_next = (r_cnt == 2'd3) ? S_DONE : S_WAIT_DATA;
        S_DONE:      w_next = S_IDLE;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the next state, plus fill context and data.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      mem_rdy_h        <= 1'b0;
      mem_to_cache_h   <= '0;
      csh_par_bit_in_h <= 1'b1;
      csh_sel_l        <= 4'b1111;
      cache_wr_l       <= 4'b1111;
      fill_busy_h      <= 1'b0;
      fill_done_h      <= 1'b0;
      fill_err_h       <= 1'b0;
      r_way            <= '0;
      r_wd             <= '0;
      r_cnt            <= '0;
    end else begin
      mem_rdy_h   <= (w_next == S_WAIT_DATA);
      fill_busy_h <= (w_next != S_IDLE);
      fill_done_h <= (w_next == S_DONE);
      fill_err_h  <= w_tmo_exit;

      // Only the captured way ever sees a low select/strobe.
      if (w_next == S_WRITE) begin
        csh_sel_l  <= ~(4'b0001 << r_way);
        cache_wr_l <= ~(4'b0001 << r_way);
      end else begin
        csh_sel_l  <= 4'b1111;
        cache_wr_l <= 4'b1111;
      end

      // Data and parity stay put for the whole strobe cycle that follows.
      if (w_xfer && !fill_abort_h) begin
        mem_to_cache_h   <= mem_data_h;
        csh_par_bit_in_h <= ~^mem_data_h;
      end

      if (!fill_abort_h) begin
        if (r_state == S_IDLE && fill_req_h) begin
          r_way <= fill_way_h;
          r_wd  <= fill_wd_h;
          r_cnt <= 2'd0;
        end else if (r_state == S_WRITE) begin
          r_wd  <= r_wd + 2'd1;
          r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csh_fill_seq.sv
// Testbench for csh_fill_seq: random fills plus directed cases, checked by a
// scoreboard. Stimulus pushes the expected cache writes / done / error events
// into a queue; a monitor on the falling edge pops and compares them.

module tb_csh_fill_seq;

  localparam int TMO = 256;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        fill_req_h;
  logic [1:0]  fill_way_h;
  logic [1:0]  fill_wd_h;
  logic        fill_abort_h;
  logic [0:35] mem_data_h;
  logic        mem_valid_h;
  logic        mem_rdy_h;
  logic [0:35] mem_to_cache_h;
  logic        csh_par_bit_in_h;
  logic [1:0]  cache_wd_adr_h;
  logic [3:0]  csh_sel_l;
  logic [3:0]  cache_wr_l;
  logic        fill_busy_h;
  logic        fill_done_h;
  logic        fill_err_h;

  csh_fill_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .reset_l          (reset_l),
    .fill_req_h       (fill_req_h),
    .fill_way_h       (fill_way_h),
    .fill_wd_h        (fill_wd_h),
    .fill_abort_h     (fill_abort_h),
    .mem_data_h       (mem_data_h),
    .mem_valid_h      (mem_valid_h),
    .mem_rdy_h        (mem_rdy_h),
    .mem_to_cache_h   (mem_to_cache_h),
    .csh_par_bit_in_h (csh_par_bit_in_h),
    .cache_wd_adr_h   (cache_wd_adr_h),
    .csh_sel_l        (csh_sel_l),
    .cache_wr_l       (cache_wr_l),
    .fill_busy_h      (fill_busy_h),
    .fill_done_h      (fill_done_h),
    .fill_err_h       (fill_err_h)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum logic [1:0] {EV_WR, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [1:0]  way;
    logic [1:0]  adr;
    logic [0:35] data;
    logic        par;
    int          at_cyc;  // -1: any cycle
  } ev_t;

  ev_t exp_q[$];

  // 37-bit word+parity must hold an odd number of ones.
  function automatic logic model_par(input logic [0:35] d);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] way);
    logic [3:0] m;
    m = 4'b1111;
    m[way] = 1'b0;
    return m;
  endfunction

  function automatic logic [0:35] rand36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  function automatic ev_t mk_ev(input ev_kind_e k, input logic [1:0] way, input logic [1:0] adr,
                                input logic [0:35] d, input int at_cyc);
    ev_t e;
    e.kind = k; e.way = way; e.adr = adr; e.data = d; e.par = model_par(d); e.at_cyc = at_cyc;
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    ev_t e;
    logic [3:0] m;
    if (cache_wr_l !== 4'b1111) begin
      wr_seen++;
      if (exp_q.size() == 0 || exp_q[0].kind != EV_WR) begin
        check("unexpected_write", {60'd0, cache_wr_l}, 64'hF);
      end else begin
        e = exp_q.pop_front();
        m = model_mask(e.way);
        check("wr_l",  {60'd0, cache_wr_l}, {60'd0, m});
        check("sel_l", {60'd0, csh_sel_l},  {60'd0, m});
        check("wd_adr", {62'd0, cache_wd_adr_h}, {62'd0, e.adr});
        check("data", {28'd0, mem_to_cache_h}, {28'd0, e.data});
        check("parity", {63'd0, csh_par_bit_in_h}, {63'd0, e.par});
      end
    end else if (csh_sel_l !== 4'b1111) begin
      check("sel_without_wr", {60'd0, csh_sel_l}, 64'hF);
    end
    if (fill_done_h === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].kind != EV_DONE) begin
        check("unexpected_done", {63'd0, fill_done_h}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.at_cyc >= 0) check("done_cycle", cyc, e.at_cyc);
      end
    end
    if (fill_err_h === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].kind != EV_ERR) begin
        check("unexpected_err", {63'd0, fill_err_h}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("err_cycle", cyc, e.at_cyc);
        check("busy_at_err", {63'd0, fill_busy_h}, 64'd0);
      end
    end
  end

  // ---------------- stimulus helpers (phase: 1 time unit after posedge) ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [1:0] way, input logic [1:0] wd, output int req_cyc);
    fill_req_h = 1'b1;
    fill_way_h = way;
    fill_wd_h  = wd;
    tick();
    req_cyc    = cyc;
    fill_req_h = 1'b0;
    fill_way_h = 2'($urandom);
    fill_wd_h  = 2'($urandom);
    check("rdy_after_req", {63'd0, mem_rdy_h}, 64'd1);
  endtask

  task automatic send_word(input logic [1:0] way, input logic [1:0] adr, input logic [0:35] d,
                           input int gap, input bit hold);
    int n;
    if (gap > 0) begin
      mem_valid_h = 1'b0;
      repeat (gap) tick();
    end
    mem_valid_h = 1'b1;
    mem_data_h  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_rdy_h === 1'b1) break;
      n++;
      if (n >= 50) begin
        check("rdy_timeout", {63'd0, mem_rdy_h}, 64'd1);
        mem_valid_h = 1'b0;
        tick();
        return;
      end
    end
    exp_q.push_back(mk_ev(EV_WR, way, adr, d, -1));
    tick();
    mem_valid_h = hold;
    mem_data_h  = rand36();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // nw < 4 aborts after nw words; abort_wait=1 aborts in WAIT_DATA with valid up.
  task automatic run_fill(input logic [1:0] way, input logic [1:0] wd, input logic [0:35] w [4],
                          input int nw, input bit hold, input int max_gap,
                          input bit abort_wait, input bit timed);
    int rc;
    start_fill(way, wd, rc);
    for (int i = 0; i < nw; i++) begin
      send_word(way, 2'(wd + 2'(i)), w[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0, hold);
    end
    if (nw == 4) begin
      exp_q.push_back(mk_ev(EV_DONE, way, 2'd0, 36'd0, timed ? rc + 8 : -1));
      wait_drain();
    end else begin
      if (abort_wait) begin
        if (nw > 0) tick();
        mem_valid_h = 1'b1;
      end
      fill_abort_h = 1'b1;
      tick();
      fill_abort_h = 1'b0;
      check("abort_busy", {63'd0, fill_busy_h}, 64'd0);
      check("abort_rdy",  {63'd0, mem_rdy_h},   64'd0);
      repeat (2) tick();
      wait_drain();
    end
    mem_valid_h = 1'b0;
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [0:35] w [4];
    int rc;
    int w0;

    reset_l = 1'b1; fill_req_h = 1'b0; fill_way_h = '0; fill_wd_h = '0;
    fill_abort_h = 1'b0; mem_data_h = '0; mem_valid_h = 1'b0;
    #1 reset_l = 1'b0;
    #2;
    check("rst_busy", {63'd0, fill_busy_h}, 64'd0);
    check("rst_rdy",  {63'd0, mem_rdy_h},   64'd0);
    check("rst_par",  {63'd0, csh_par_bit_in_h}, 64'd1);
    check("rst_wr",   {60'd0, cache_wr_l}, 64'hF);
    #19 reset_l = 1'b1;
    tick();

    // Basic fill: way 2, first word 1, back-to-back data, done 10 cycles after req.
    w[0] = 36'o1; w[1] = 36'o2; w[2] = 36'o3; w[3] = 36'o4;
    run_fill(2'd2, 2'd1, w, 4, 1'b0, 0, 1'b0, 1'b1);

    // Parity corner words.
    w[0] = 36'o0; w[1] = 36'o1; w[2] = 36'o777777777777; w[3] = 36'o400000000001;
    run_fill(2'd0, 2'd3, w, 4, 1'b0, 1, 1'b0, 1'b0);

    // Stall/ignore: valid held through WRITE/DONE/IDLE, second request while busy.
    w0 = wr_seen;
    start_fill(2'd1, 2'd2, rc);
    for (int i = 0; i < 4; i++) begin
      w[i] = rand36();
      send_word(2'd1, 2'(2'd2 + 2'(i)), w[i], 0, 1'b1);
      if (i == 1) begin
        fill_req_h = 1'b1; fill_way_h = 2'd3;
        tick();
        fill_req_h = 1'b0;
      end
    end
    exp_q.push_back(mk_ev(EV_DONE, 2'd1, 2'd0, 36'd0, -1));
    wait_drain();
    repeat (4) tick();
    check("stall_busy", {63'd0, fill_busy_h}, 64'd0);
    mem_valid_h = 1'b0;
    tick();
    check("stall_strobes", wr_seen - w0, 4);

    // Abort after the second write.
    w0 = wr_seen;
    for (int i = 0; i < 4; i++) w[i] = rand36();
    run_fill(2'd3, 2'd0, w, 2, 1'b0, 0, 1'b0, 1'b0);
    check("abort_strobes", wr_seen - w0, 2);

    // Abort in WAIT_DATA with valid present: abort wins, no third write.
    w0 = wr_seen;
    run_fill(2'd0, 2'd2, w, 2, 1'b1, 0, 1'b1, 1'b0);
    check("abort_wait_strobes", wr_seen - w0, 2);

    // Reset asserted mid-WRITE.
    start_fill(2'd3, 2'd1, rc);
    send_word(2'd3, 2'd1, 36'o123456701234, 0, 1'b0);
    #1;
    check("pre_reset_wr", {60'd0, cache_wr_l}, {60'd0, model_mask(2'd3)});
    reset_l = 1'b0;
    #1;
    exp_q.delete();
    check("reset_wr",    {60'd0, cache_wr_l}, 64'hF);
    check("reset_sel",   {60'd0, csh_sel_l},  64'hF);
    check("reset_data",  {28'd0, mem_to_cache_h}, 64'd0);
    check("reset_par",   {63'd0, csh_par_bit_in_h}, 64'd1);
    check("reset_adr",   {62'd0, cache_wd_adr_h}, 64'd0);
    check("reset_rdy",   {63'd0, mem_rdy_h}, 64'd0);
    check("reset_busy",  {63'd0, fill_busy_h}, 64'd0);
    check("reset_done",  {63'd0, fill_done_h}, 64'd0);
    check("reset_err",   {63'd0, fill_err_h}, 64'd0);
    #10 reset_l = 1'b1;
    tick();
    check("post_reset_busy", {63'd0, fill_busy_h}, 64'd0);

    // Timeout behaviour.
`ifdef CSH_FILL_TIMEOUT_EN
    start_fill(2'd1, 2'd0, rc);
    exp_q.push_back(mk_ev(EV_ERR, 2'd0, 2'd0, 36'd0, rc + TMO));
    wait_drain();
    check("tmo_busy", {63'd0, fill_busy_h}, 64'd0);
`else
    start_fill(2'd1, 2'd0, rc);
    repeat (TMO + 40) tick();
    check("no_tmo_busy", {63'd0, fill_busy_h}, 64'd1);
    check("no_tmo_rdy",  {63'd0, mem_rdy_h},   64'd1);
    fill_abort_h = 1'b1;
    tick();
    fill_abort_h = 1'b0;
    check("no_tmo_abort_busy", {63'd0, fill_busy_h}, 64'd0);
`endif
    tick();

    // Random fills: random way/word/data, gaps, held valid, occasional aborts.
    for (int t = 0; t < 30; t++) begin
      int nw;
      for (int i = 0; i < 4; i++) w[i] = rand36();
      nw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4;
      run_fill(2'($urandom), 2'($urandom), w, nw, 1'($urandom), $urandom_range(0, 3),
               1'($urandom), 1'b0);
    end

    repeat (3) tick();
    check("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
